// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl
// Bit-serial subtract controller. Sequences one external combinational 1-bit
// full subtractor to compute result = a - b - bin (mod 2^WIDTH), LSB first,
// one bit pair per clock, then pulses done for one cycle.
//
// Optional feature: define SUB_OVF_EN to add the ovf output, the signed
// two's-complement overflow of a - b - bin, registered alongside bout.
//
// Ports
//   clk, reset       rising-edge clock, synchronous active-high reset
//   start            request, sampled only in IDLE
//   a, b, bin        operands, latched when start is accepted
//   busy             high while bits are being processed
//   done             one-cycle pulse, result/bout valid
//   result, bout     difference and final borrow, held until next accepted start
//   ovf              (SUB_OVF_EN only) signed overflow, held with result
//   fs_x/fs_y/fs_z   drive the external subtractor (a bit, b bit, running borrow)
//   fs_diff/fs_borrow  combinational outputs of the external subtractor
module serial_sub_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             bout,
`ifdef SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             fs_x,
  output logic             fs_y,
  output logic             fs_z,
  input  logic             fs_diff,
  input  logic             fs_borrow
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             borrow_q, borrow_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             bout_q, bout_d;
`ifdef SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      bout_q   <= 1'b0;
`ifdef SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      bout_q   <= bout_d;
`ifdef SUB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    bout_d   = bout_q;
`ifdef SUB_OVF_EN
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StRun;
          a_sh_d   = a;
          b_sh_d   = b;
          borrow_d = bin;
          cnt_d    = '0;
        end
      end
      StRun: begin
        // Diff bits enter at the MSB so bit i lands in place after WIDTH shifts.
        result_d           = result_q >> 1;
        result_d[WIDTH-1]  = fs_diff;
        borrow_d           = fs_borrow;
        a_sh_d             = a_sh_q >> 1;
        b_sh_d             = b_sh_q >> 1;
        cnt_d              = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          bout_d  = fs_borrow;
`ifdef SUB_OVF_EN
          // On the last bit the shifters hold the operand MSBs and fs_diff is the
          // result MSB.
          ovf_d   = (a_sh_q[0] ^ b_sh_q[0]) & (fs_diff ^ a_sh_q[0]);
`endif
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy   = (state_q == StRun);
    done   = (state_q == StDone);
    fs_x   = busy & a_sh_q[0];
    fs_y   = busy & b_sh_q[0];
    fs_z   = busy & borrow_q;
    result = result_q;
    bout   = bout_q;
`ifdef SUB_OVF_EN
    ovf    = ovf_q;
`endif
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
module tb_serial_sub_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, start, bin;
  logic [W-1:0] a, b;
  logic         busy, done, bout, fs_x, fs_y, fs_z, fs_diff, fs_borrow;
  logic [W-1:0] result;
`ifdef SUB_OVF_EN
  logic         ovf;
`endif

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .result(result), .bout(bout),
`ifdef SUB_OVF_EN
    .ovf(ovf),
`endif
    .fs_x(fs_x), .fs_y(fs_y), .fs_z(fs_z), .fs_diff(fs_diff), .fs_borrow(fs_borrow)
  );

  // External full subtractor cell.
  assign fs_diff   = fs_x ^ fs_y ^ fs_z;
  assign fs_borrow = (~fs_x & fs_y) | (~(fs_x ^ fs_y) & fs_z);

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference for a - b - bin.
  function automatic logic [W-1:0] ref_res(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
    int d;
    d = int'(x) - int'(y) - int'(c);
    return W'(d);
  endfunction

  function automatic logic ref_borrow(input logic [W-1:0] x, input logic [W-1:0] y,
                                      input logic c);
    return int'(x) < int'(y) + int'(c);
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c);
    int sx, sy, d;
    sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
    sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
    d  = sx - sy - int'(c);
    return (d < -(1 << (W - 1))) || (d > (1 << (W - 1)) - 1);
  endfunction

  // Behavioural model: phase 0 idle, 1..W processing bit phase-1, W+1 done.
  int           phase = 0;
  bit           m_valid = 1'b0;
  logic [W-1:0] la, lb, m_res;
  logic         lbin, m_bout, m_ovf;

  always @(posedge clk) begin
    if (reset) begin
      phase = 0; m_res = '0; m_bout = 1'b0; m_ovf = 1'b0; m_valid = 1'b1;
    end else if (phase == 0) begin
      if (start) begin
        la = a; lb = b; lbin = bin; phase = 1;
      end
    end else if (phase <= W) begin
      if (phase == W) begin
        m_res  = ref_res(la, lb, lbin);
        m_bout = ref_borrow(la, lb, lbin);
        m_ovf  = ref_ovf(la, lb, lbin);
      end
      phase++;
    end else begin
      phase = 0;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      logic ex, ey, ez;
      int   i, mask;
      ex = 1'b0; ey = 1'b0; ez = 1'b0;
      if (phase >= 1 && phase <= W) begin
        i    = phase - 1;
        mask = (1 << i) - 1;
        ex   = la[i];
        ey   = lb[i];
        ez   = (int'(la) & mask) < (int'(lb) & mask) + int'(lbin);
      end
      chk("busy", busy, phase >= 1 && phase <= W);
      chk("done", done, phase == W + 1);
      chk("fs_x", fs_x, ex);
      chk("fs_y", fs_y, ey);
      chk("fs_z", fs_z, ez);
      if (phase == 0 || phase == W + 1) begin
        chk("result", result, m_res);
        chk("bout", bout, m_bout);
`ifdef SUB_OVF_EN
        chk("ovf", ovf, m_ovf);
`endif
      end
    end
  end

  // Starts one operation from IDLE and returns in the done cycle (edge + 1ns).
  task automatic do_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci,
                       input logic [W-1:0] er, input logic eb, input logic eo,
                       input bit hold_start);
    int cyc, busy_n, lat;
    bit got;
    @(posedge clk); #1;
    start = 1'b1; a = ai; b = bi; bin = ci;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    chk("first_fs_x", fs_x, ai[0]);
    chk("first_fs_y", fs_y, bi[0]);
    chk("first_fs_z", fs_z, ci);
    cyc = 1; busy_n = 0; got = 1'b0; lat = 0;
    while (cyc <= W + 5 && !got) begin
      if (busy) busy_n++;
      if (done) begin
        got = 1'b1;
        lat = cyc;
        start = 1'b0;
      end else begin
        if (hold_start) begin
          a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    chk("done_seen", got, 1'b1);
    chk("latency", lat, W + 1);
    chk("busy_cycles", busy_n, W);
    chk("op_result", result, er);
    chk("op_bout", bout, eb);
`ifdef SUB_OVF_EN
    chk("op_ovf", ovf, eo);
`else
    if (eo === 1'bx) $display("unexpected X");
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int dn;
    logic [W-1:0] ra, rb;
    logic rc;
    reset = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_result", result, '0);
    chk("rst_bout", bout, 1'b0);

    // Hand-computed cases.
    do_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
    do_op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0);
    do_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    do_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
    do_op(8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 1'b0, 1'b0);

    // start held through RUN with moving operands.
    do_op(8'h9C, 8'h27, 1'b1, 8'h74, 1'b0, 1'b1, 1'b1);

    // Reset four cycles into RUN.
    @(posedge clk); #1;
    start = 1'b1; a = 8'h3C; b = 8'hC3; bin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_result", result, '0);
    chk("abort_fs", {fs_x, fs_y, fs_z}, 3'b000);
    dn = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    chk("abort_no_done", dn, 0);
    do_op(8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0);

    // Random operations, some back-to-back, some with idle gaps.
    repeat (30) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      do_op(ra, rb, rc, ref_res(ra, rb, rc), ref_borrow(ra, rb, rc), ref_ovf(ra, rb, rc),
            1'($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
